uart_tx_sched: RTL

Transmit scheduler for `simple_uart`: shares the single UART transmitter between `N_REQ` byte producers (e.g. soft-CPU console, OPL3 debug trace). Round-robin arbitration into a FIFO. A sequencer FSM drains the FIFO by driving the UART's edge-triggered `wstrb`/`dat` and waiting for its one-cycle `ready` pulse. Sits between producers and `simple_uart`; a watchdog recovers if the UART never answers, e.g. because it was reset mid-byte.

---
 rtl/uart_sched_pkg.sv | 16 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_tx_sched.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Contents: sequencer state enum, ASCII CR/LF codes, default watchdog limit.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } sched_state_e;

  localparam logic [7:0]  ASCII_CR           = 8'h0D;
  localparam logic [7:0]  ASCII_LF           = 8'h0A;
  localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd12000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Ports: clk, rst (async active-low), push/din, pop/dout (head, valid when
// !empty), full, empty, level (0..DEPTH). Push while full and pop while empty
// are ignored. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push_c, do_pop_c;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign dout  = mem_q[rd_q];
  assign level = level_q;

  // Pointer and occupancy update
  always_comb begin
    do_push_c = push & ~full;
    do_pop_c  = pop & ~empty;
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (do_push_c) wr_d = wr_q + AW'(1);
    if (do_pop_c)  rd_d = rd_q + AW'(1);
    level_d = level_q + LW'(do_push_c) - LW'(do_pop_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one simple_uart transmitter between N_REQ byte producers:
// round-robin arbiter -> sync_fifo -> sequencer (IDLE/LOAD/STROBE/GAP) that
// holds uart_wstrb high until uart_ready or the watchdog expires.
// Ports: clk, rst (async active-low); req_valid/req_data/req_ready per
// producer (byte i at req_data[8i+7:8i]); uart_wstrb/uart_dat/uart_ready to
// the UART; busy, fifo_level, timeout (one-cycle abort pulse).
// Build option: UART_TX_SCHED_CRLF_EN inserts a CR before every LF.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned DEPTH          = 16,
  parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     uart_wstrb,
  output logic [7:0]               uart_dat,
  input  logic                     uart_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     timeout
);
  localparam int unsigned RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  sched_state_e      state_q, state_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic [15:0]       wd_q, wd_d;
  logic [7:0]        dat_q, dat_d;
  logic              wstrb_q, wstrb_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              arb_en_q;
`ifdef UART_TX_SCHED_CRLF_EN
  logic              cr_pend_q, cr_pend_d;
`endif

  logic [RR_W-1:0]   idx_c, gnt_c;
  logic              gnt_vld_c, push_c, pop_c;
  logic [7:0]        push_data_c, fifo_head;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  lvl_nxt_c;

  assign uart_wstrb = wstrb_q;
  assign uart_dat   = dat_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;

  // Round-robin grant: scan downward so the lowest offset from rr_q wins
  always_comb begin
    idx_c       = '0;
    gnt_c       = '0;
    gnt_vld_c   = 1'b0;
    push_data_c = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx_c = RR_W'((int'(rr_q) + k) % int'(N_REQ));
      if (req_valid[idx_c]) begin
        gnt_c     = idx_c;
        gnt_vld_c = 1'b1;
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt_c == RR_W'(i)) push_data_c = req_data[8*i +: 8];
    end
    // Fullness is judged at cycle start; a same-cycle pop does not open a slot
    push_c    = arb_en_q & gnt_vld_c & ~fifo_full;
    req_ready = '0;
    if (push_c) req_ready[gnt_c] = 1'b1;
    rr_d = rr_q;
    if (push_c) rr_d = RR_W'((int'(gnt_c) + 1) % int'(N_REQ));
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .din   (push_data_c),
    .pop   (pop_c),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Sequencer next state and registered outputs
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    dat_d     = dat_q;
    timeout_d = 1'b0;
    pop_c     = 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
    cr_pend_d = cr_pend_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        state_d = STROBE;
        wd_d    = '0;
`ifdef UART_TX_SCHED_CRLF_EN
        // First visit to an LF sends CR and leaves the LF at the head
        if (fifo_head == ASCII_LF && !cr_pend_q) begin
          dat_d     = ASCII_CR;
          cr_pend_d = 1'b1;
        end else begin
          dat_d     = fifo_head;
          pop_c     = 1'b1;
          cr_pend_d = 1'b0;
        end
`else
        dat_d = fifo_head;
        pop_c = 1'b1;
`endif
      end
      STROBE: begin
        wd_d = wd_q + 16'd1;
        if (uart_ready) begin
          state_d = GAP;
          wd_d    = '0;
        end else if (wd_q == TIMEOUT_CYCLES - 16'd1) begin
          // Byte is dropped, not retried
          state_d   = GAP;
          wd_d      = '0;
          timeout_d = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wstrb_d   = (state_d == STROBE);
    lvl_nxt_c = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
    busy_d    = (state_d != IDLE) || (lvl_nxt_c != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      wd_q      <= '0;
      dat_q     <= '0;
      wstrb_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      arb_en_q  <= 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
      cr_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      wd_q      <= wd_d;
      dat_q     <= dat_d;
      wstrb_q   <= wstrb_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      arb_en_q  <= 1'b1;
`ifdef UART_TX_SCHED_CRLF_EN
      cr_pend_q <= cr_pend_d;
`endif
    end
  end

endmodule
